// File: rtl/rv32i_mtimer_if.sv
// Bus between a core and the machine timer: one request held until a
// single-cycle bus_ready response.
interface rv32i_mtimer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;
  logic              bus_err;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready, bus_err
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready, bus_err
  );
endinterface

// File: rtl/rv32i_mtimer.sv
// RV32I machine timer: 48-bit prescaled mtime, 48-bit compare, level MTIP,
// with an atomic LO-then-HI read through a 16-bit shadow.
module rv32i_mtimer #(
  parameter int unsigned RESET_DIV = 0,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_mtimer_if.slave        bus,
  output logic [47:0]          mtime,
  output logic                 timer_interrupt
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept_c;

  logic [15:0] shadow;
  logic [47:0] mtimecmp;
  logic        en;
  logic        ie;
  logic [7:0]  div;
  logic [7:0]  pc;

  logic [WORD_W-1:0] word_c;
  logic sel_mlo_c, sel_mhi_c, sel_clo_c, sel_chi_c, sel_ctrl_c, mapped_c;
  logic wr_c, rd_c, tick_c;
  logic [31:0] rdata_c;
  logic unused_addr_bits;

  assign word_c           = bus.bus_addr[ADDR_W-1:2];
  assign unused_addr_bits = ^bus.bus_addr[1:0];

  assign sel_mlo_c  = (word_c == WORD_W'(0));
  assign sel_mhi_c  = (word_c == WORD_W'(1));
  assign sel_clo_c  = (word_c == WORD_W'(2));
  assign sel_chi_c  = (word_c == WORD_W'(3));
  assign sel_ctrl_c = (word_c == WORD_W'(4));
  assign mapped_c   = sel_mlo_c | sel_mhi_c | sel_clo_c | sel_chi_c | sel_ctrl_c;

  assign wr_c   = accept_c &  bus.bus_we & mapped_c;
  assign rd_c   = accept_c & ~bus.bus_we & mapped_c;
  assign tick_c = en & (pc == div);

  // Bus FSM: accept in IDLE, respond for exactly one cycle in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_valid) begin
          accept_c = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux; MTIME_HI returns the shadow captured by the last MTIME_LO read.
  always_comb begin
    rdata_c = 32'd0;
    if (sel_mlo_c)  rdata_c = mtime[31:0];
    if (sel_mhi_c)  rdata_c = {16'd0, shadow};
    if (sel_clo_c)  rdata_c = mtimecmp[31:0];
    if (sel_chi_c)  rdata_c = {16'd0, mtimecmp[47:32]};
    if (sel_ctrl_c) rdata_c = {16'd0, div, 6'd0, ie, en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime           <= 48'd0;
      shadow          <= 16'd0;
      mtimecmp        <= 48'hFFFF_FFFF_FFFF;
      en              <= 1'b1;
      ie              <= 1'b0;
      div             <= 8'(RESET_DIV);
      pc              <= 8'd0;
      bus.bus_ready   <= 1'b0;
      bus.bus_err     <= 1'b0;
      bus.bus_rdata   <= 32'd0;
      timer_interrupt <= 1'b0;
    end else begin
      bus.bus_ready   <= accept_c;
      bus.bus_err     <= accept_c & ~mapped_c;
      bus.bus_rdata   <= (accept_c & ~bus.bus_we) ? rdata_c : 32'd0;
      timer_interrupt <= ie & (mtime >= mtimecmp);

      // An mtime write wins over that cycle's tick.
      if (wr_c && sel_mlo_c)      mtime <= {mtime[47:32], bus.bus_wdata};
      else if (wr_c && sel_mhi_c) mtime <= {bus.bus_wdata[15:0], mtime[31:0]};
      else if (tick_c)            mtime <= mtime + 48'd1;

      if (wr_c && sel_ctrl_c) pc <= 8'd0;
      else if (en)            pc <= tick_c ? 8'd0 : pc + 8'd1;

      if (rd_c && sel_mlo_c) shadow <= mtime[47:32];
      if (wr_c && sel_clo_c) mtimecmp[31:0]  <= bus.bus_wdata;
      if (wr_c && sel_chi_c) mtimecmp[47:32] <= bus.bus_wdata[15:0];
      if (wr_c && sel_ctrl_c) begin
        en  <= bus.bus_wdata[0];
        ie  <= bus.bus_wdata[1];
        div <= bus.bus_wdata[15:8];
      end
    end
  end

endmodule

// File: doc/rv32i_mtimer.md
RV32I_MTIMER -- requirements
Module: rv32i_mtimer

Interface
REQ-001 The block SHALL have parameter RESET_DIV, default 0: prescaler divide value loaded at reset.
REQ-002 The block SHALL have parameter ADDR_W, default 5: width of bus_addr (byte address).
REQ-003 The block SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have bus_valid, input, 1: request present; held with all request fields stable until bus_ready.
REQ-006 The block SHALL have bus_we, input, 1: 1 = write, 0 = read.
REQ-007 The block SHALL have bus_addr, input, ADDR_W: word-aligned register address; bits [1:0] ignored.
REQ-008 The block SHALL have bus_wdata, input, 32: write data.
REQ-009 The block SHALL have bus_rdata, output, 32: read data, valid while bus_ready=1.
REQ-010 The block SHALL have bus_ready, output, 1: one-cycle response pulse completing the request.
REQ-011 The block SHALL have bus_err, output, 1: unmapped address; valid with bus_ready.
REQ-012 The block SHALL have mtime, output, 48: free-running timer value (CSR time/cycle/instret source).
REQ-013 The block SHALL have timer_interrupt, output, 1: registered machine timer interrupt (MTIP).

Function
REQ-014 Register map SHALL be: 0x00 MTIME_LO [31:0]; 0x04 MTIME_HI [15:0], upper bits read 0; 0x08 CMP_LO; 0x0C CMP_HI [15:0]; 0x10 CTRL (bit0 EN, bit1 IE, bits[15:8] DIV); other addresses unmapped.
REQ-015 Bus FSM SHALL have states IDLE and RESP: IDLE + bus_valid -> RESP (access performed on this edge); RESP -> IDLE unconditionally, with bus_ready=1 only in RESP.
REQ-016 Latency SHALL be exactly one cycle from acceptance to bus_ready; back-to-back requests SHALL be accepted every second cycle.
REQ-017 An unmapped access SHALL return bus_rdata=0 and bus_err=1, and SHALL alter no state.
REQ-018 Prescaler SHALL be an 8-bit counter PC: when EN=1, PC==DIV gives a tick and PC<=0, else PC<=PC+1; when EN=0, PC and mtime hold.
REQ-019 On tick, mtime SHALL increment by 1 modulo 2^48; 48'hFFFF_FFFF_FFFF SHALL wrap to 0 with no other side effect.
REQ-020 A write to MTIME_LO SHALL set mtime[31:0] <= wdata, keep mtime[47:32], and suppress that cycle's increment; MTIME_HI write likewise sets [47:32] <= wdata[15:0].
REQ-021 A CTRL write SHALL reset PC to 0.
REQ-022 A MTIME_LO read SHALL capture mtime[47:32] into a 16-bit shadow on the same edge; MTIME_HI reads SHALL return the shadow, giving an atomic 48-bit LO-then-HI read.
REQ-023 timer_interrupt SHALL be registered as IE && (mtime >= mtimecmp) (48-bit unsigned), using post-edge register values one cycle later.
REQ-024 timer_interrupt SHALL be level-based and cleared only by raising mtimecmp above mtime, advancing mtime below it (write), or clearing IE.
REQ-025 A bus write and a tick in the same cycle to a field other than mtime SHALL both take effect.

Reset
REQ-026 On rst=1 the block SHALL immediately set: mtime=0, shadow=0, mtimecmp=48'hFFFF_FFFF_FFFF, EN=1, IE=0, DIV=RESET_DIV, PC=0, FSM=IDLE, bus_ready=0, bus_err=0, bus_rdata=0, timer_interrupt=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no bus_ready issued; the master SHALL re-issue it after reset.

Verification
REQ-028 Reset release, DIV=0: after 10 cycles MTIME_LO reads 10 +/- 1 cycle of access latency; bus_ready exactly 1 cycle after bus_valid.
REQ-029 Write CTRL=0x0000_0303 (DIV=3, EN, IE): mtime increments once per 4 cycles; CMP=0x20: timer_interrupt rises the cycle after mtime reaches 0x20; CMP_LO write 0x40 drops it the cycle after.
REQ-030 Write MTIME_HI=0xFFFF, MTIME_LO=0xFFFF_FFFE with DIV=0: two ticks later mtime=0, no interrupt (mtimecmp at reset value).
REQ-031 Atomic read: mtime=0x0000_FFFF_FFFF at the LO read -> LO=0xFFFF_FFFF, HI=0x0000 despite carry before the HI read.
REQ-032 Read address 0x14 -> bus_err=1, bus_rdata=0, no register changed; EN=0 -> mtime frozen over 100 cycles.
REQ-033 Assert rst during RESP with IE=1, interrupt active -> timer_interrupt=0 and bus_ready=0 immediately, all registers at their reset values.
